// File: rtl/cntr_uart_reporter.sv
// cntr_uart_reporter
// Watches the 4-bit one-second counter and, whenever its value changes,
// transmits "<hex digit>\r\n" on an 8N1 UART line so a host terminal can
// log the count. A change that arrives while a message is in flight is held
// in a one-deep pending slot (latest value wins). A sticky overrun flag is
// raised when the pending value gets overwritten.
module cntr_uart_reporter #(
  parameter int CLK_HZ       = 200000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input  logic       CLK,
  input  logic       FPGA_CPU_RESET,
  input  logic [3:0] counter_up,
  output logic       uart_tx,
  output logic       tx_busy,
  output logic       overrun
);

  localparam int             TW       = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0]  BIT_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0]  TMR_ONE  = TW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        r_state;
  logic [3:0]    r_cnt_q;
  logic [3:0]    r_prev_val;
  logic [3:0]    r_msg_val;
  logic [3:0]    r_pend_val;
  logic          r_pending;
  logic          r_overrun;
  logic          r_tx;
  logic [1:0]    r_byte_idx;
  logic [2:0]    r_bit_idx;
  logic [TW-1:0] r_timer;

  logic          w_change;
  logic          w_pend_any;
  logic [3:0]    w_pend_src;
  logic          w_bit_done;
  logic [7:0]    w_byte;

  // Uppercase ASCII hex digit for a nibble.
  function automatic logic [7:0] hex_ascii(input logic [3:0] v);
    if (v <= 4'd9) return 8'h30 + {4'h0, v};
    else           return 8'h37 + {4'h0, v};
  endfunction

  assign w_change   = (r_cnt_q != r_prev_val);
  // A change in the very last stop cycle counts as pending for the
  // follow-on decision, so it is sent back-to-back with no idle gap.
  assign w_pend_any = r_pending | w_change;
  assign w_pend_src = w_change ? r_cnt_q : r_pend_val;
  assign w_bit_done = (r_timer == BIT_LAST);

  // Select the byte of the message currently being serialised.
  always_comb begin
    // NOTE: a default assignment first keeps every path driven, so no latch.
    w_byte = 8'h0A;
    case (r_byte_idx)
      2'd0:    w_byte = hex_ascii(r_msg_val);
      2'd1:    w_byte = 8'h0D;
      default: w_byte = 8'h0A;
    endcase
  end

  // Change detection, pending capture and the transmit FSM.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (FPGA_CPU_RESET) begin
      r_state    <= S_IDLE;
      r_cnt_q    <= 4'h0;
      r_prev_val <= 4'h0;
      r_msg_val  <= 4'h0;
      r_pend_val <= 4'h0;
      r_pending  <= 1'b0;
      r_overrun  <= 1'b0;
      r_tx       <= 1'b1;
      r_byte_idx <= 2'd0;
      r_bit_idx  <= 3'd0;
      r_timer    <= '0;
    end else begin
      r_cnt_q <= counter_up;
      if (w_change) r_prev_val <= r_cnt_q;

      // Changes during a message go to the pending slot; the FSM below may
      // consume the slot in the same cycle (its assignment then wins).
      if (w_change && (r_state != S_IDLE)) begin
        r_pend_val <= r_cnt_q;
        r_pending  <= 1'b1;
        if (r_pending) r_overrun <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          r_tx       <= 1'b1;
          r_timer    <= '0;
          r_byte_idx <= 2'd0;
          r_bit_idx  <= 3'd0;
          if (w_change || r_pending) begin
            r_msg_val <= w_pend_src;
            r_pending <= 1'b0;
            r_tx      <= 1'b0;
            r_state   <= S_START;
          end
        end

        S_START: begin
          if (w_bit_done) begin
            r_timer   <= '0;
            r_bit_idx <= 3'd0;
            r_tx      <= w_byte[0];
            r_state   <= S_DATA;
          end else begin
            r_timer <= r_timer + TMR_ONE;
          end
        end

        S_DATA: begin
          if (w_bit_done) begin
            r_timer <= '0;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= w_byte[r_bit_idx + 3'd1];
            end
          end else begin
            r_timer <= r_timer + TMR_ONE;
          end
        end

        S_STOP: begin
          if (w_bit_done) begin
            r_timer <= '0;
            if (r_byte_idx < 2'd2) begin
              r_byte_idx <= r_byte_idx + 2'd1;
              r_tx       <= 1'b0;
              r_state    <= S_START;
            end else if (w_pend_any) begin
              r_msg_val  <= w_pend_src;
              r_pending  <= 1'b0;
              r_byte_idx <= 2'd0;
              r_tx       <= 1'b0;
              r_state    <= S_START;
            end else begin
              r_byte_idx <= 2'd0;
              r_tx       <= 1'b1;
              r_state    <= S_IDLE;
            end
          end else begin
            r_timer <= r_timer + TMR_ONE;
          end
        end

        default: begin
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign uart_tx = r_tx;
  assign tx_busy = (r_state != S_IDLE) | r_pending;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_cntr_uart_reporter.sv
// Directed bench for cntr_uart_reporter: a fast instance (16 clocks/bit)
// for framing, hex range, coalescing and reset, plus a default-rate
// instance for the real bit period and message length.
module tb_cntr_uart_reporter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cnt0, cnt1;
  logic       tx0, busy0, ovr0;
  logic       tx1, busy1, ovr1;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int busy_cnt0   = 0;
  int busy_cnt1   = 0;
  int idle_bad    = 0;
  bit mon_idle    = 0;

  localparam int FAST_CPB = 16;

  cntr_uart_reporter #(.CLK_HZ(1600), .BAUD(100)) u_fast (
    .CLK(clk), .FPGA_CPU_RESET(rst), .counter_up(cnt0),
    .uart_tx(tx0), .tx_busy(busy0), .overrun(ovr0)
  );

  cntr_uart_reporter u_dflt (
    .CLK(clk), .FPGA_CPU_RESET(rst), .counter_up(cnt1),
    .uart_tx(tx1), .tx_busy(busy1), .overrun(ovr1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (busy0 === 1'b1) busy_cnt0++;
    if (busy1 === 1'b1) busy_cnt1++;
    if (mon_idle && (tx0 !== 1'b1 || busy0 !== 1'b0 || ovr0 !== 1'b0)) idle_bad++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic line(input int sel);
    return (sel != 0) ? tx1 : tx0;
  endfunction

  // Wait for a start bit, then sample mid-cell: start, 8 data bits, stop.
  task automatic rx_byte(input int sel, input int cpb, output int waited,
                         output logic [7:0] data, output logic frame_ok);
    waited = 0;
    data   = 8'h00;
    while (line(sel) !== 1'b0 && waited < 4 * cpb + 20) begin
      @(negedge clk);
      waited++;
    end
    repeat (cpb / 2) @(negedge clk);
    frame_ok = (line(sel) === 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (cpb) @(negedge clk);
      data[i] = line(sel);
    end
    repeat (cpb) @(negedge clk);
    frame_ok = frame_ok && (line(sel) === 1'b1);
  endtask

  // Receive "<digit>\r\n"; later bytes must follow with no gap.
  task automatic recv_msg(input int sel, input int cpb, input logic [7:0] digit,
                          input int first_wait, input string tag);
    logic [7:0] exp_b [3];
    int         w;
    logic [7:0] d;
    logic       ok;
    exp_b[0] = digit;
    exp_b[1] = 8'h0D;
    exp_b[2] = 8'h0A;
    for (int b = 0; b < 3; b++) begin
      rx_byte(sel, cpb, w, d, ok);
      check($sformatf("%s_wait%0d", tag, b), w, (b == 0) ? first_wait : cpb / 2);
      check($sformatf("%s_byte%0d", tag, b), d, exp_b[b]);
      check($sformatf("%s_frame%0d", tag, b), ok, 1);
    end
  endtask

  task automatic wait_busy_low(input int sel, input int budget, input string tag);
    int n = 0;
    while (((sel != 0) ? busy1 : busy0) !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_busy_drop"}, (n < budget), 1);
  endtask

  initial begin
    string hexs = "0123456789ABCDEF";
    int t0, w, low, bad;

    // 1: reset and idle
    rst  = 1'b1;
    cnt0 = 4'h0;
    cnt1 = 4'h0;
    repeat (5) @(negedge clk);
    check("rst_tx", tx0, 1);
    check("rst_busy", busy0, 0);
    check("rst_ovr", ovr0, 0);
    check("rst_tx_dflt", tx1, 1);
    rst = 1'b0;
    mon_idle = 1'b1;
    repeat (1000) @(negedge clk);
    mon_idle = 1'b0;
    check("idle_1000", idle_bad, 0);

    // 2: single message 0 -> 5
    busy_cnt0 = 0;
    cnt0 = 4'h5;
    recv_msg(0, FAST_CPB, 8'h35, 2, "single");
    wait_busy_low(0, 100, "single");
    repeat (20) @(negedge clk);
    check("single_busy_cycles", busy_cnt0, 480);

    // 3: hex range 1..15 then wrap to 0
    for (int v = 1; v <= 16; v++) begin
      t0   = cyc;
      cnt0 = 4'(v % 16);
      recv_msg(0, FAST_CPB, hexs[v % 16], 2, $sformatf("hex%0d", v % 16));
      while (cyc - t0 < 600) @(negedge clk);
    end
    check("hex_no_overrun", ovr0, 0);

    // 4: coalesce 3, +50 -> 7, +60 -> 9
    busy_cnt0 = 0;
    fork
      begin
        cnt0 = 4'h3;
        repeat (50) @(negedge clk);
        cnt0 = 4'h7;
        repeat (60) @(negedge clk);
        cnt0 = 4'h9;
      end
      begin
        recv_msg(0, FAST_CPB, 8'h33, 2, "coal_a");
        recv_msg(0, FAST_CPB, 8'h39, FAST_CPB / 2, "coal_b");
      end
    join
    wait_busy_low(0, 100, "coal");
    repeat (20) @(negedge clk);
    check("coal_busy_cycles", busy_cnt0, 960);
    check("coal_overrun", ovr0, 1);

    // 5: reset mid-message
    cnt0 = 4'hA;
    repeat (202) @(negedge clk);
    check("midrst_inflight", busy0, 1);
    rst  = 1'b1;
    cnt0 = 4'h0;
    @(negedge clk);
    check("midrst_tx", tx0, 1);
    check("midrst_busy", busy0, 0);
    check("midrst_ovr", ovr0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (600) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || busy0 !== 1'b0) bad++;
    end
    check("midrst_quiet", bad, 0);

    // 6: default rate, 0 -> 1
    busy_cnt1 = 0;
    cnt1 = 4'h1;
    w = 0;
    while (tx1 !== 1'b0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("dflt_start_lat", w, 2);
    low = 0;
    while (tx1 === 1'b0 && low < 3000) begin
      @(negedge clk);
      low++;
    end
    check("dflt_start_len", low, 1736);
    wait_busy_low(1, 60000, "dflt");
    repeat (5) @(negedge clk);
    check("dflt_busy_cycles", busy_cnt1, 52080);
    check("dflt_tx_idle", tx1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
